// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, IR field positions,
// FSM state encoding and opcode classification helpers.
package ctrl_pkg;

  // IR field bit positions
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RR, C_IMM, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILL
  } op_class_t;

  // Group opcodes by the execute sequence they need
  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    c = C_ILL;
    if (op >= OP_ADD && op <= OP_SHL)       c = C_RR;
    else if (op >= OP_ADDI && op <= OP_ORI) c = C_IMM;
    else if (op == OP_MUL || op == OP_DIV)  c = C_MULDIV;
    else if (op == OP_NEG || op == OP_NOT)  c = C_UNARY;
    else if (op == OP_NOP)                  c = C_NOP;
    else if (op == OP_HALT)                 c = C_HALT;
    return c;
  endfunction

  // Immediate forms reuse the ALU operation of their reg-reg counterpart
  function automatic logic [4:0] alu_op(input logic [4:0] op);
    logic [4:0] r;
    case (op)
      OP_ADDI: r = OP_ADD;
      OP_ANDI: r = OP_AND;
      OP_ORI:  r = OP_OR;
      default: r = op;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_reg_select.sv
// Register index decoder: 4-bit index plus enable to a one-hot select vector.
module reg_select #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       idx,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sel
      assign onehot[gi] = en && (int'(idx) == gi);
    end
  endgenerate

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute control unit for the 32-bit datapath.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  input  logic             start,
  output logic             PC_out,
  output logic             Zlo_out,
  output logic             Zhi_out,
  output logic             MDR_out,
  output logic             C_out,
  output logic             MAR_rd,
  output logic             PC_rd,
  output logic             MDR_rd,
  output logic             IR_rd,
  output logic             Y_rd,
  output logic             Zlo_rd,
  output logic             HI_rd,
  output logic             LO_rd,
  output logic             IncPC,
  output logic             Read,
  output logic [NREGS-1:0] R_rd,
  output logic [NREGS-1:0] R_wrt,
  output logic [4:0]       op_sel,
  output logic             run,
  output logic             illegal
);

  state_t     state_reg, state_next;
  logic       t1_wait_reg;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  op_class_t  cls;
  logic [3:0] rd_idx, wrt_idx;
  logic       rd_en, wrt_en;
  logic       unused_ir;

  assign op        = ir[OP_HI:OP_LO];
  assign ra        = ir[RA_HI:RA_LO];
  assign rb        = ir[RB_HI:RB_LO];
  assign rc        = ir[RC_HI:RC_LO];
  assign cls       = op_class(op);
  assign unused_ir = ^ir[RC_LO-1:0];

  // State register; t1_wait_reg marks T1 cycles after the first one
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= S_IDLE;
      t1_wait_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      t1_wait_reg <= (state_reg == S_T1) && (state_next == S_T1);
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_HALT: if (start) state_next = S_T0;
      S_T0:           state_next = S_T1;
      S_T1:           if (mem_rdy) state_next = S_T2;
      S_T2: begin
        case (cls)
          C_NOP, C_ILL: state_next = S_T0;
          C_HALT:       state_next = S_HALT;
          default:      state_next = S_T3;
        endcase
      end
      S_T3:           state_next = S_T4;
      S_T4:           state_next = (cls == C_UNARY) ? S_T0 : S_T5;
      S_T5:           state_next = (cls == C_MULDIV) ? S_T6 : S_T0;
      S_T6:           state_next = S_T0;
      default:        state_next = S_IDLE;
    endcase
  end

  // Output decode from state and IR; everything held low while clr is high
  always_comb begin
    PC_out = 1'b0; Zlo_out = 1'b0; Zhi_out = 1'b0; MDR_out = 1'b0; C_out = 1'b0;
    MAR_rd = 1'b0; PC_rd = 1'b0; MDR_rd = 1'b0; IR_rd = 1'b0; Y_rd = 1'b0;
    Zlo_rd = 1'b0; HI_rd = 1'b0; LO_rd = 1'b0; IncPC = 1'b0; Read = 1'b0;
    op_sel = 5'd0; run = 1'b0; illegal = 1'b0;
    rd_idx = ra; rd_en = 1'b0; wrt_idx = rb; wrt_en = 1'b0;
    if (!clr) begin
      run = (state_reg != S_IDLE) && (state_reg != S_HALT);
      case (state_reg)
        S_T0: begin
          PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1;
        end
        S_T1: begin
          Zlo_out = 1'b1; Read = 1'b1; MDR_rd = 1'b1;
          PC_rd   = !t1_wait_reg;
        end
        S_T2: begin
          MDR_out = 1'b1; IR_rd = 1'b1;
          illegal = (cls == C_ILL);
        end
        S_T3: begin
          wrt_en = 1'b1;
          if (cls == C_UNARY) begin
            op_sel = op; Zlo_rd = 1'b1;
          end else begin
            Y_rd = 1'b1;
          end
        end
        S_T4: begin
          if (cls == C_UNARY) begin
            Zlo_out = 1'b1; rd_en = 1'b1;
          end else begin
            op_sel = alu_op(op); Zlo_rd = 1'b1;
            if (cls == C_IMM) begin
              C_out = 1'b1;
            end else begin
              wrt_idx = rc; wrt_en = 1'b1;
            end
          end
        end
        S_T5: begin
          Zlo_out = 1'b1;
          if (cls == C_MULDIV) LO_rd = 1'b1;
          else                 rd_en = 1'b1;
        end
        S_T6: begin
          Zhi_out = 1'b1; HI_rd = 1'b1;
        end
        default: ;
      endcase
    end
  end

  reg_select #(.NREGS(NREGS)) u_rd_sel (
    .idx    (rd_idx),
    .en     (rd_en),
    .onehot (R_rd)
  );

  reg_select #(.NREGS(NREGS)) u_wrt_sel (
    .idx    (wrt_idx),
    .en     (wrt_en),
    .onehot (R_wrt)
  );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed-vector bench for ctrl_sequencer: checks strobes, register selects
// and op_sel cycle by cycle against hand-computed values.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        clr, mem_rdy, start;
  logic [31:0] ir;
  logic PC_out, Zlo_out, Zhi_out, MDR_out, C_out, MAR_rd, PC_rd, MDR_rd, IR_rd;
  logic Y_rd, Zlo_rd, HI_rd, LO_rd, IncPC, Read, run, illegal;
  logic [15:0] R_rd, R_wrt;
  logic [4:0]  op_sel;
  logic [16:0] strobes;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [16:0] PCO  = 17'h1 << 16;
  localparam logic [16:0] ZLOO = 17'h1 << 15;
  localparam logic [16:0] ZHIO = 17'h1 << 14;
  localparam logic [16:0] MDRO = 17'h1 << 13;
  localparam logic [16:0] CO   = 17'h1 << 12;
  localparam logic [16:0] MARR = 17'h1 << 11;
  localparam logic [16:0] PCR  = 17'h1 << 10;
  localparam logic [16:0] MDRR = 17'h1 << 9;
  localparam logic [16:0] IRR  = 17'h1 << 8;
  localparam logic [16:0] YR   = 17'h1 << 7;
  localparam logic [16:0] ZLOR = 17'h1 << 6;
  localparam logic [16:0] HIR  = 17'h1 << 5;
  localparam logic [16:0] LOR  = 17'h1 << 4;
  localparam logic [16:0] INC  = 17'h1 << 3;
  localparam logic [16:0] RD   = 17'h1 << 2;
  localparam logic [16:0] RUN  = 17'h1 << 1;
  localparam logic [16:0] ILL  = 17'h1;

  localparam logic [16:0] ST_T0  = PCO | MARR | INC | ZLOR | RUN;
  localparam logic [16:0] ST_T1  = ZLOO | PCR | RD | MDRR | RUN;
  localparam logic [16:0] ST_T1W = ZLOO | RD | MDRR | RUN;
  localparam logic [16:0] ST_T2  = MDRO | IRR | RUN;

  assign strobes = {PC_out, Zlo_out, Zhi_out, MDR_out, C_out, MAR_rd, PC_rd, MDR_rd,
                    IR_rd, Y_rd, Zlo_rd, HI_rd, LO_rd, IncPC, Read, run, illegal};

  always #5 clk = ~clk;

  ctrl_sequencer #(.NREGS(16)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy), .start(start),
    .PC_out(PC_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .MDR_out(MDR_out),
    .C_out(C_out), .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
    .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .HI_rd(HI_rd), .LO_rd(LO_rd), .IncPC(IncPC),
    .Read(Read), .R_rd(R_rd), .R_wrt(R_wrt), .op_sel(op_sel), .run(run),
    .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [16:0] s,
                              input logic [15:0] rrd, input logic [15:0] rwrt,
                              input logic [4:0] ops);
    check({tag, ".strobes"}, 32'(strobes), 32'(s));
    check({tag, ".R_rd"},    32'(R_rd),    32'(rrd));
    check({tag, ".R_wrt"},   32'(R_wrt),   32'(rwrt));
    check({tag, ".op_sel"},  32'(op_sel),  32'(ops));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_rdy = 1'b1; ir = 32'h2A1B8000;
    tick();
    expect_cycle("rst0", 17'd0, 16'h0, 16'h0, 5'd0);
    tick();
    expect_cycle("rst1", 17'd0, 16'h0, 16'h0, 5'd0);
    clr = 1'b0; start = 1'b1;
    #1;
    expect_cycle("idle", 17'd0, 16'h0, 16'h0, 5'd0);

    // and r4,r3,r7, no memory wait
    tick(); start = 1'b0;
    expect_cycle("and.T0", ST_T0, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("and.T1", ST_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("and.T2", ST_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("and.T3", YR | RUN, 16'h0, 16'h0008, 5'd0);
    tick(); expect_cycle("and.T4", ZLOR | RUN, 16'h0, 16'h0080, 5'b00101);
    tick(); expect_cycle("and.T5", ZLOO | RUN, 16'h0010, 16'h0, 5'd0);
    tick(); expect_cycle("and.T0b", ST_T0, 16'h0, 16'h0, 5'd0);

    // shr r4,r3,r7 with three T1 wait cycles
    ir = 32'h4A1B8000; mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_cycle($sformatf("shr.T1_%0d", i), (i == 0) ? ST_T1 : ST_T1W, 16'h0, 16'h0, 5'd0);
      if (i == 3) mem_rdy = 1'b1;
    end
    tick(); expect_cycle("shr.T2", ST_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("shr.T3", YR | RUN, 16'h0, 16'h0008, 5'd0);
    tick(); expect_cycle("shr.T4", ZLOR | RUN, 16'h0, 16'h0080, 5'b01001);
    tick(); expect_cycle("shr.T5", ZLOO | RUN, 16'h0010, 16'h0, 5'd0);
    tick(); expect_cycle("shr.T0", ST_T0, 16'h0, 16'h0, 5'd0);

    // mul r3,r4
    ir = 32'h781A0000;
    tick(); expect_cycle("mul.T1", ST_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("mul.T2", ST_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("mul.T3", YR | RUN, 16'h0, 16'h0008, 5'd0);
    tick(); expect_cycle("mul.T4", ZLOR | RUN, 16'h0, 16'h0010, 5'b01111);
    tick(); expect_cycle("mul.T5", ZLOO | LOR | RUN, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("mul.T6", ZHIO | HIR | RUN, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("mul.T0", ST_T0, 16'h0, 16'h0, 5'd0);

    // addi r2,r5,imm
    ir = {5'b01100, 4'd2, 4'd5, 4'd0, 15'h1234};
    tick(); expect_cycle("addi.T1", ST_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("addi.T2", ST_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("addi.T3", YR | RUN, 16'h0, 16'h0020, 5'd0);
    tick(); expect_cycle("addi.T4", CO | ZLOR | RUN, 16'h0, 16'h0, 5'b00011);
    tick(); expect_cycle("addi.T5", ZLOO | RUN, 16'h0004, 16'h0, 5'd0);
    tick(); expect_cycle("addi.T0", ST_T0, 16'h0, 16'h0, 5'd0);

    // not r1,r6
    ir = {5'b10010, 4'd1, 4'd6, 4'd0, 15'd0};
    tick(); expect_cycle("not.T1", ST_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("not.T2", ST_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("not.T3", ZLOR | RUN, 16'h0, 16'h0040, 5'b10010);
    tick(); expect_cycle("not.T4", ZLOO | RUN, 16'h0002, 16'h0, 5'd0);
    tick(); expect_cycle("not.T0", ST_T0, 16'h0, 16'h0, 5'd0);

    // unsupported opcode 11111
    ir = 32'hF8000000;
    tick(); expect_cycle("ill.T1", ST_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("ill.T2", ST_T2 | ILL, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("ill.T0", ST_T0, 16'h0, 16'h0, 5'd0);

    // halt, then restart
    ir = {5'b11011, 27'd0};
    tick(); expect_cycle("halt.T1", ST_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("halt.T2", ST_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("halt.H0", 17'd0, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("halt.H1", 17'd0, 16'h0, 16'h0, 5'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    expect_cycle("halt.T0", ST_T0, 16'h0, 16'h0, 5'd0);

    // add r4,r4,r4 reset in T4, with start raised at the same time
    ir = {5'b00011, 4'd4, 4'd4, 4'd4, 15'd0};
    tick(); expect_cycle("clr.T1", ST_T1, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("clr.T2", ST_T2, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("clr.T3", YR | RUN, 16'h0, 16'h0010, 5'd0);
    tick(); expect_cycle("clr.T4", ZLOR | RUN, 16'h0, 16'h0010, 5'b00011);
    clr = 1'b1; start = 1'b1;
    #1;
    expect_cycle("clr.hold", 17'd0, 16'h0, 16'h0, 5'd0);
    tick(); expect_cycle("clr.idle0", 17'd0, 16'h0, 16'h0, 5'd0);
    clr = 1'b0; start = 1'b0;
    tick(); expect_cycle("clr.idle1", 17'd0, 16'h0, 16'h0, 5'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    expect_cycle("clr.T0", ST_T0, 16'h0, 16'h0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
